// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the single register-file write port, with one registered
// output stage that doubles as a forwarding bypass. Optional macro: RF_ARB_ZERO_FILTER_EN.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        dbg_valid,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_addr_w,
  output logic [31:0] rf_data_w,
  output logic        byp_valid,
  output logic [4:0]  byp_addr,
  output logic [31:0] byp_data,
  output logic [3:0]  starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        wen_q, wen_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  starve_q, starve_d;

  logic        conflict;
  logic        grant_wb;
  logic        grant_dbg;
  logic        stage;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    conflict  = wb_valid & dbg_valid;
    // Debug wins when alone, or when it has lost STARVE_LIMIT conflicts in a row.
    grant_dbg = dbg_valid & (~wb_valid | (starve_q == LIMIT));
    grant_wb  = wb_valid & ~grant_dbg;
    win_addr  = grant_dbg ? dbg_addr : wb_addr;
    win_data  = grant_dbg ? dbg_data : wb_data;

`ifdef RF_ARB_ZERO_FILTER_EN
    stage = (grant_wb | grant_dbg) && (win_addr != 5'd0);
`else
    stage = grant_wb | grant_dbg;
`endif

    wen_d  = stage;
    addr_d = addr_q;
    data_d = data_q;
    if (stage) begin
      addr_d = win_addr;
      data_d = win_data;
    end

    starve_d = starve_q;
    if (grant_dbg) begin
      starve_d = 4'd0;
    end else if (conflict && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wen_q    <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 32'd0;
      starve_q <= 4'd0;
    end else begin
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      starve_q <= starve_d;
    end
  end

  // Readies are forced low for the whole time reset is held.
  assign wb_ready   = rst_n & grant_wb;
  assign dbg_ready  = rst_n & grant_dbg;

  assign rf_wen     = wen_q;
  assign rf_addr_w  = addr_q;
  assign rf_data_w  = data_q;
  assign byp_valid  = wen_q;
  assign byp_addr   = addr_q;
  assign byp_data   = data_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: the driver checks readies and starvation count each
// cycle and queues expected writes; a negedge monitor pops them as rf_* presents them.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid, dbg_valid;
  logic [4:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;
  logic        wb_ready, dbg_ready;
  logic        rf_wen, byp_valid;
  logic [4:0]  rf_addr_w, byp_addr;
  logic [31:0] rf_data_w, byp_data;
  logic [3:0]  starve_cnt;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned cyc = 0;
  logic        rst_at_edge = 1'b1;
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_data = 32'd0;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ready  (dbg_ready),
    .rf_wen     (rf_wen),
    .rf_addr_w  (rf_addr_w),
    .rf_data_w  (rf_data_w),
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= ~rst_n;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected write whenever the staged write is live, else checks the hold.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      last_addr = 5'd0;
      last_data = 32'd0;
    end
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {63'd0, rf_wen}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("wr_addr", 64'(rf_addr_w), 64'(mon_e.addr));
        check("wr_data", 64'(rf_data_w), 64'(mon_e.data));
        check("byp_valid", {63'd0, byp_valid}, 64'd1);
        check("byp_addr", 64'(byp_addr), 64'(mon_e.addr));
        check("byp_data", 64'(byp_data), 64'(mon_e.data));
        last_addr = mon_e.addr;
        last_data = mon_e.data;
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check("missing_write", {63'd0, rf_wen}, 64'd1);
        void'(exp_q.pop_front());
      end
      check("hold_addr", 64'(rf_addr_w), 64'(last_addr));
      check("hold_data", 64'(rf_data_w), 64'(last_data));
      check("hold_byp_valid", {63'd0, byp_valid}, 64'd0);
      check("hold_byp_addr", 64'(byp_addr), 64'(last_addr));
      check("hold_byp_data", 64'(byp_data), 64'(last_data));
    end
  end

  // One cycle of stimulus with hand-computed readies and post-edge starvation count.
  task automatic vec(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                     input logic dv, input logic [4:0] da, input logic [31:0] dd,
                     input logic exp_wr, input logic exp_dr, input logic [3:0] exp_sc);
    exp_t e;
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    dbg_valid = dv;
    dbg_addr  = da;
    dbg_data  = dd;
    @(negedge clk);
    check("wb_ready", {63'd0, wb_ready}, {63'd0, exp_wr});
    check("dbg_ready", {63'd0, dbg_ready}, {63'd0, exp_dr});
    if (exp_wr || exp_dr) begin
      e.cyc  = cyc + 1;
      e.addr = exp_dr ? da : wa;
      e.data = exp_dr ? dd : wd;
`ifdef RF_ARB_ZERO_FILTER_EN
      if (e.addr != 5'd0) exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
    @(posedge clk);
    #1;
    check("starve_cnt", 64'(starve_cnt), 64'(exp_sc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    // Reset with both requesters asserting: both readies must stay low.
    vec(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 4'd0);
    vec(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 4'd0);
    rst_n = 1'b1;

    // Single-port writes from each side.
    vec(1, 5'd3,  32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 4'd0);
    vec(0, 5'd0,  32'h0,        0, 5'd0, 32'h0, 0, 0, 4'd0);
    vec(0, 5'd0,  32'h0,        1, 5'd9, 32'h1234, 0, 1, 4'd0);

    // Promotion: continuous conflict, debug request held until accepted.
    vec(1, 5'd1,  32'h1001, 1, 5'd10, 32'h100, 1, 0, 4'd1);
    vec(1, 5'd2,  32'h1002, 1, 5'd10, 32'h100, 1, 0, 4'd2);
    vec(1, 5'd3,  32'h1003, 1, 5'd10, 32'h100, 1, 0, 4'd3);
    vec(1, 5'd4,  32'h1004, 1, 5'd10, 32'h100, 1, 0, 4'd4);
    vec(1, 5'd6,  32'h1006, 1, 5'd10, 32'h100, 0, 1, 4'd0);
    vec(1, 5'd6,  32'h1006, 1, 5'd11, 32'h200, 1, 0, 4'd1);
    vec(1, 5'd8,  32'h1008, 1, 5'd11, 32'h200, 1, 0, 4'd2);
    vec(1, 5'd9,  32'h1009, 1, 5'd11, 32'h200, 1, 0, 4'd3);
    vec(1, 5'd13, 32'h100D, 1, 5'd11, 32'h200, 1, 0, 4'd4);
    vec(1, 5'd14, 32'h100E, 1, 5'd11, 32'h200, 0, 1, 4'd0);
    vec(1, 5'd14, 32'h100E, 0, 5'd0,  32'h0,   1, 0, 4'd0);

    // Idle hold after a write of addr 7.
    vec(1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 32'h0, 1, 0, 4'd0);
    vec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 4'd0);
    vec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 4'd0);
    vec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 4'd0);

    // Same-address conflict: 0x11 first, then the held 0x22.
    vec(1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 1, 0, 4'd1);
    vec(0, 5'd0, 32'h0,  1, 5'd5, 32'h22, 0, 1, 4'd0);

    // Address-0 write from debug; filtered only when the macro is defined.
    vec(0, 5'd0, 32'h0, 1, 5'd0, 32'h55, 0, 1, 4'd0);
    vec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 4'd0);

    // Reset in the cycle after an accepted write, debug still requesting.
    vec(1, 5'd20, 32'hBEEF0001, 1, 5'd21, 32'h21, 1, 0, 4'd1);
    rst_n = 1'b0;
    vec(0, 5'd0, 32'h0, 1, 5'd21, 32'h21, 0, 0, 4'd0);
    vec(0, 5'd0, 32'h0, 1, 5'd21, 32'h21, 0, 0, 4'd0);
    rst_n = 1'b1;
    vec(0, 5'd0, 32'h0, 1, 5'd21, 32'h21, 0, 1, 4'd0);
    vec(0, 5'd0, 32'h0, 0, 5'd0,  32'h0,  0, 0, 4'd0);
    vec(0, 5'd0, 32'h0, 0, 5'd0,  32'h0,  0, 0, 4'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
